// File: rtl/ascii_case_stream.sv
// Purpose: streaming ASCII case converter (pass/upper/lower/title), LANES bytes per beat, mode latched per packet.
// Latency: 1 cycle from accepted input beat to m_valid; one beat per cycle sustained.
// Backpressure: single output register; s_ready = ~m_valid | m_ready, outputs hold while m_valid & ~m_ready.
//
// Ports:
//   clk, rst                       rising-edge clock, asynchronous active-high reset
//   mode                           00 pass, 01 upper, 10 lower, 11 title (sampled on a packet's first beat)
//   s_valid/s_ready/s_data/s_keep/s_last   input beat stream, lane 0 in s_data[7:0]
//   m_valid/m_ready/m_data/m_keep/m_last   converted output stream
//   cnt_clr, conv_count            synchronous clear / saturating count of changed kept bytes
module ascii_case_stream #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*LANES-1:0]   s_data,
    input  logic [LANES-1:0]     s_keep,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [8*LANES-1:0]   m_data,
    output logic [LANES-1:0]     m_keep,
    output logic                 m_last,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     conv_count
);

    localparam int DW = 8 * LANES;
    localparam int NW = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_UPPER = 2'b01,
        MODE_LOWER = 2'b10,
        MODE_TITLE = 2'b11
    } mode_t;

    logic             in_pkt;
    logic [1:0]       pkt_mode;
    logic             word_start;

    logic             accept;
    mode_t            eff_mode;
    logic [DW-1:0]    conv_data;
    logic [NW-1:0]    chg_cnt;
    logic             ws_next;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    assign s_ready  = ~m_valid | m_ready;
    assign accept   = s_valid & s_ready;
    assign eff_mode = mode_t'(in_pkt ? pkt_mode : mode);

    // Lane-serial conversion: 'carry' is "the preceding kept character was a
    // non-letter", walked from lane 0 upward so title mode sees word boundaries
    // across lanes. The seed forces a word start on a packet's first beat;
    // word_start is already 1 there, the OR just makes that explicit.
    always_comb begin
        logic carry;
        conv_data = s_data;
        chg_cnt   = '0;
        carry     = ~in_pkt | word_start;
        for (int i = 0; i < LANES; i++) begin
            logic [7:0] c;
            logic [7:0] o;
            logic       is_up;
            logic       is_lo;
            c     = s_data[8*i +: 8];
            o     = c;
            is_up = (c >= 8'h41) && (c <= 8'h5A);
            is_lo = (c >= 8'h61) && (c <= 8'h7A);
            if (s_keep[i]) begin
                unique case (eff_mode)
                    MODE_PASS:  o = c;
                    MODE_UPPER: o = is_lo ? c - 8'h20 : c;
                    MODE_LOWER: o = is_up ? c + 8'h20 : c;
                    MODE_TITLE: begin
                        if (carry) o = is_lo ? c - 8'h20 : c;
                        else       o = is_up ? c + 8'h20 : c;
                    end
                    default:    o = c;
                endcase
                if (o != c) chg_cnt = chg_cnt + NW'(1);
                carry = ~(is_up | is_lo);
            end
            conv_data[8*i +: 8] = o;
        end
        // With no kept lane the carry is just the seed, i.e. word_start unchanged.
        ws_next = carry;
    end

    // One extra bit catches overflow so the counter clamps instead of wrapping.
    assign cnt_sum  = {1'b0, conv_count} + (CNT_W+1)'(chg_cnt);
    assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
            conv_count <= '0;
            in_pkt     <= 1'b0;
            pkt_mode   <= 2'b00;
            word_start <= 1'b1;
        end else begin
            if (accept) begin
                m_valid    <= 1'b1;
                m_data     <= conv_data;
                m_keep     <= s_keep;
                m_last     <= s_last;
                in_pkt     <= ~s_last;
                if (!in_pkt) pkt_mode <= mode;
                // Tracked in every mode so a mode switch between packets starts clean.
                word_start <= s_last ? 1'b1 : ws_next;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (cnt_clr)     conv_count <= '0;
            else if (accept) conv_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_ascii_case_stream.sv
module tb_ascii_case_stream;

    localparam int LANES = 4;
    localparam int CNT_W = 4;
    localparam int DW    = 8 * LANES;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic [LANES-1:0] s_keep;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [LANES-1:0] m_keep;
    logic             m_last;
    logic             cnt_clr;
    logic [CNT_W-1:0] conv_count;

    always #5 clk = ~clk;

    ascii_case_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_keep     (s_keep),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .cnt_clr    (cnt_clr),
        .conv_count (conv_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: expected output beats, packet/mode tracking,
    // "previous kept char was a non-letter" flag, and expected counter.
    logic [63:0] exp_q[$];
    bit          md_in_pkt;
    logic [1:0]  md_mode;
    bit          md_ws;
    int          exp_cnt;
    bit          held_vld;
    logic [63:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic l, input logic [LANES-1:0] k, input logic [DW-1:0] d);
        return {27'd0, l, k, d};
    endfunction

    function automatic bit is_letter(input logic [7:0] c);
        return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'd97 && c <= 8'd122) ? c - 8'd32 : c;
    endfunction

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return (c >= 8'd65 && c <= 8'd90) ? c + 8'd32 : c;
    endfunction

    function automatic logic [7:0] conv_char(input logic [7:0] c, input logic [1:0] md, input bit ws);
        case (md)
            2'b01:   return to_upper(c);
            2'b10:   return to_lower(c);
            2'b11:   return ws ? to_upper(c) : to_lower(c);
            default: return c;
        endcase
    endfunction

    function automatic logic [7:0] rand_char();
        case ($urandom % 6)
            0:       return 8'($urandom_range(65, 90));
            1, 2:    return 8'($urandom_range(97, 122));
            3:       return 8'h20;
            4:       return 8'($urandom_range(48, 57));
            default: return 8'($urandom % 256);
        endcase
    endfunction

    task automatic model_accept(output int n);
        logic [DW-1:0] o;
        n = 0;
        if (!md_in_pkt) begin
            md_mode = mode;
            md_ws   = 1'b1;
        end
        o = s_data;
        for (int i = 0; i < LANES; i++) begin
            if (s_keep[i]) begin
                logic [7:0] c;
                logic [7:0] oc;
                c  = s_data[8*i +: 8];
                oc = conv_char(c, md_mode, md_ws);
                o[8*i +: 8] = oc;
                if (oc != c) n++;
                md_ws = !is_letter(c);
            end
        end
        exp_q.push_back(pack(s_last, s_keep, o));
        md_in_pkt = !s_last;
    endtask

    // One clock: monitor/model at negedge, then return 1 time unit after posedge.
    task automatic cycle();
        int  n;
        bit  acc;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            md_in_pkt = 1'b0;
            exp_cnt   = 0;
            held_vld  = 1'b0;
        end else begin
            check("count", conv_count, exp_cnt);
            check("s_ready", s_ready, !m_valid || m_ready);
            if (held_vld) begin
                check("hold_vld", m_valid, 1'b1);
                check("hold_dat", pack(m_last, m_keep, m_data), held);
            end
            if (m_valid && m_ready) begin
                check("q_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("beat", pack(m_last, m_keep, m_data), exp_q.pop_front());
            end
            held_vld = m_valid && !m_ready;
            held     = pack(m_last, m_keep, m_data);
            acc = s_valid && (!m_valid || m_ready);
            n   = 0;
            if (acc) model_accept(n);
            if (cnt_clr)  exp_cnt = 0;
            else if (acc) exp_cnt = (exp_cnt + n > CMAX) ? CMAX : exp_cnt + n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] md, input logic [DW-1:0] d, input logic [LANES-1:0] k, input logic l);
        mode    = md;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] bp [5];
        rst = 1'b1; mode = 2'b00; s_valid = 1'b0; s_data = '0; s_keep = '0;
        s_last = 1'b0; m_ready = 1'b1; cnt_clr = 1'b0;
        md_in_pkt = 1'b0; md_mode = 2'b00; md_ws = 1'b1; exp_cnt = 0; held_vld = 1'b0; held = '0;
        repeat (2) cycle();
        rst = 1'b0;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_cnt", conv_count, 0);

        // Upper / lower at the letter range boundaries
        send(2'b01, 32'h7A61405B, 4'hF, 1'b1);
        check("up_data", m_data, 32'h5A41405B);
        check("up_vld", m_valid, 1'b1);
        check("up_cnt", conv_count, 2);
        send(2'b10, 32'h5A41605B, 4'hF, 1'b1);
        check("lo_data", m_data, 32'h7A61605B);
        check("lo_cnt", conv_count, 4);

        // Title across beats, then a fresh packet
        send(2'b11, 32'h77206968, 4'hF, 1'b0);
        check("title1", m_data, 32'h57206948);
        send(2'b11, 32'h444C524F, 4'hF, 1'b1);
        check("title2", m_data, 32'h646C726F);
        check("title_cnt", conv_count, 10);
        send(2'b11, 32'h00000061, 4'hF, 1'b1);
        check("title_new", m_data, 32'h00000041);

        // Keep mask and per-packet mode latch
        send(2'b01, 32'h61616161, 4'h3, 1'b0);
        check("keep_data", m_data, 32'h61614141);
        check("keep_keep", m_keep, 4'h3);
        send(2'b10, 32'h41414141, 4'hF, 1'b1);
        check("latch_data", m_data, 32'h41414141);
        check("latch_cnt", conv_count, 13);

        cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        check("clr_cnt", conv_count, 0);

        // Saturation, then clear winning over a simultaneous increment
        repeat (5) send(2'b01, 32'h61616161, 4'hF, 1'b1);
        check("sat_cnt", conv_count, CMAX);
        cnt_clr = 1'b1;
        send(2'b01, 32'h61616161, 4'hF, 1'b1);
        cnt_clr = 1'b0;
        check("clr_win", conv_count, 0);
        check("clr_data", m_data, 32'h41414141);

        // Backpressure: stall 5 cycles, then stream one beat per cycle
        for (int i = 0; i < 5; i++) bp[i] = 32'h61626364 + 32'h01010101 * i;
        cycle();
        m_ready = 1'b0; mode = 2'b01; s_keep = 4'hF; s_last = 1'b1; s_valid = 1'b1;
        s_data = bp[0];
        cycle();
        check("bp_s_ready", s_ready, 1'b0);
        for (int i = 1; i < 5; i++) begin
            s_data = bp[i];
            cycle();
        end
        check("bp_data", m_data, bp[0] - 32'h20202020);
        check("bp_cnt", conv_count, 4);
        m_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            s_data = bp[i];
            cycle();
            check("bp_stream", m_data, bp[i] - 32'h20202020);
        end
        s_valid = 1'b0;
        cycle();
        check("bp_sat", conv_count, CMAX);

        // Asynchronous reset mid-packet
        send(2'b11, 32'h41424344, 4'hF, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_m_valid", m_valid, 1'b0);
        check("arst_s_ready", s_ready, 1'b1);
        check("arst_cnt", conv_count, 0);
        cycle();
        rst = 1'b0;
        send(2'b01, 32'h20616263, 4'hF, 1'b1);
        check("arst_newpkt", m_data, 32'h20414243);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            s_valid = ($urandom % 4) != 0;
            m_ready = ($urandom % 4) != 0;
            mode    = 2'($urandom);
            s_keep  = 4'($urandom);
            s_last  = ($urandom % 3) == 0;
            cnt_clr = ($urandom % 40) == 0;
            for (int i = 0; i < LANES; i++) s_data[8*i +: 8] = rand_char();
            rst = ($urandom % 500) == 0;
            cycle();
            rst = 1'b0;
        end

        s_valid = 1'b0; m_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) cycle();
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascii_case_stream.md
Name: ascii_case_stream

Overview:
- Streaming, parametrised successor to the 8-bit combinational upper-case converter.
- Processes LANES ASCII bytes per beat under a valid/ready handshake.
- Applies one of four case modes: pass, upper, lower, title. Mode is latched per packet.
- Registered output stage; title mode carries word-boundary state across lanes and beats; saturating counter of modified characters.

Parameters:
- LANES, 4, bytes per beat; data width is 8*LANES, lane 0 in bits [7:0].
- CNT_W, 16, width of the modified-character counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  00 pass, 01 upper, 10 lower, 11 title; sampled on the first accepted beat of a packet.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  8*LANES  input characters.
- s_keep  in  LANES  per-lane byte-valid.
- s_last  in  1  final beat of packet.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts.
- m_data  out  8*LANES  converted characters.
- m_keep  out  LANES  copy of s_keep.
- m_last  out  1  copy of s_last.
- cnt_clr  in  1  synchronous clear of conv_count.
- conv_count  out  CNT_W  number of kept lanes whose byte was changed; saturates.

Behaviour:
- Reset (async, immediate) clears the following: m_valid=0, m_data=0, m_keep=0, m_last=0, conv_count=0, in_pkt=0, pkt_mode=00, word_start=1.
- Accept condition: s_valid & s_ready, with s_ready = ~m_valid | m_ready (single pipeline register, full throughput). Latency is 1 cycle from accept to m_valid.
- On accept, m_data/m_keep/m_last load and m_valid=1. If m_ready & ~accept, m_valid clears. While m_valid & ~m_ready, outputs hold stable.
- Classification: upper letter = 0x41..0x5A; lower letter = 0x61..0x7A; all other codes (digits, punctuation, >=0x80) are non-letters and pass unchanged in every mode.
- Mode latching:
  - effective mode = mode when in_pkt=0, else pkt_mode.
  - On an accepted beat with in_pkt=0, pkt_mode<=mode.
  - in_pkt<=~s_last on every accept.
  - Mode changes mid-packet are ignored.
- Per-mode conversion:
  - upper: lower letter minus 0x20.
  - lower: upper letter plus 0x20.
  - pass: unchanged.
  - title: a letter at a word start becomes upper; any other letter becomes lower.
- Word start (title): a lane is a word start if the preceding kept character is a non-letter. "Preceding" means the lower kept lane in the same beat, else word_start carried from the previous beat. The first character of a packet is always a word start.
- word_start register:
  - On accept, set to 1 if s_last.
  - Otherwise set to (highest kept lane is a non-letter).
  - If no lane is kept, it is unchanged.
  - Updated in all modes, so a mode switch at a packet boundary always starts clean.
- Non-kept lanes: byte passed through unchanged, excluded from word-boundary evaluation and counting.
- Counter:
  - On accept, conv_count += number of kept lanes where output != input. The sum is computed at CNT_W+1 bits and clamped to 2^CNT_W-1.
  - cnt_clr clears the counter and wins over a simultaneous increment.
- Reset mid-packet: the in-flight beat is dropped. The next accepted beat is treated as a packet start.
- s_valid with s_keep=0 is legal: the beat is forwarded with no conversion and no count.

Test Plan:
- Reset: assert rst asynchronously between edges → m_valid=0, s_ready=1, conv_count=0 immediately, before the next clk edge.
- Upper, boundaries: LANES=4, mode=01, s_data=0x7A61405B, keep=0xF, last=1 → next cycle m_data=0x5A41405B, m_valid=1, conv_count=2. Then mode=10, s_data=0x5A41605B → m_data=0x7A61605B, conv_count=4.
- Title across beats: mode=11, beat1 0x77206968 ("hi w"), beat2 0x444C524F ("ORLD", last) → 0x57206948 then 0x646C726F, count +6. Then a new packet 0x00000061 → 0x00000041.
- Keep/mode latch: mode=01 on beat1 (keep=0x3, data 0x61616161, last=0), mode driven 10 on beat2 (data 0x41414141, last=1) → beat1 0x61614141, beat2 0x41414141 unchanged, count +2.
- Backpressure: hold m_ready=0 for 5 cycles with s_valid=1 → s_ready=0 after the first accept, m_data stable, no count change. Raising m_ready resumes one beat per cycle with no loss or duplication.
- Saturation/clear: CNT_W=4, drive 5 all-lowercase upper-mode beats → conv_count=15 and held. cnt_clr asserted together with an accepted beat → conv_count=0.
